// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem handshake, one-entry response buffer and IF/ID register
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCWrite,
    input  logic        stall_IF_ID,
    input  logic        flush_IF_ID,
    input  logic        branch_taken_ID,
    input  logic [31:0] branch_target_ID,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_IF_ID,
    output logic [31:0] instr_IF_ID,
    output logic        valid_IF_ID
);
    typedef enum logic [1:0] {BOOT, ISSUE, WAIT, BUFFERED} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx, held, held_nx, word, target;
    logic        kill, kill_nx, redirect, accept, deliver;

    assign redirect  = branch_taken_ID & PCWrite;
    assign accept    = ~stall_IF_ID & ~flush_IF_ID & ~redirect;
    assign target    = {branch_target_ID[31:2], 2'b00};
    assign word      = (state == BUFFERED) ? held : imem_rdata;
    assign imem_req  = (state == ISSUE);
    assign imem_addr = pc;

    // Next state, PC, kill flag and buffer; a request killed by a redirect still owes one response that must be swallowed
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        kill_nx  = kill;
        held_nx  = held;
        deliver  = 1'b0;
        case (state)
            BOOT: state_nx = ISSUE;
            ISSUE: begin
                state_nx = WAIT;
                if (redirect) begin
                    pc_nx   = target;
                    kill_nx = 1'b1;
                end
            end
            WAIT: begin
                if (!imem_rvalid) begin
                    if (redirect) begin
                        pc_nx   = target;
                        kill_nx = 1'b1;
                    end
                end else if (kill) begin
                    kill_nx  = 1'b0;
                    state_nx = ISSUE;
                    if (redirect) pc_nx = target;
                end else if (redirect) begin
                    pc_nx    = target;
                    state_nx = ISSUE;
                end else if (accept && PCWrite) begin
                    deliver  = 1'b1;
                    pc_nx    = pc + 32'd4;
                    state_nx = ISSUE;
                end else begin
                    held_nx  = imem_rdata;
                    state_nx = BUFFERED;
                end
            end
            BUFFERED: begin
                if (redirect) begin
                    pc_nx    = target;
                    state_nx = ISSUE;
                end else if (accept && PCWrite) begin
                    deliver  = 1'b1;
                    pc_nx    = pc + 32'd4;
                    state_nx = ISSUE;
                end
            end
            default: state_nx = BOOT;
        endcase
    end

    // Fetch-side state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc    <= RESET_PC;
            kill  <= 1'b0;
            held  <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            kill  <= kill_nx;
            held  <= held_nx;
        end
    end

    // IF/ID register: stall holds, delivery loads, anything else leaves a bubble with the old PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_IF_ID    <= '0;
            instr_IF_ID <= NOP_INSTR;
            valid_IF_ID <= 1'b0;
        end else if (!stall_IF_ID) begin
            if (deliver) begin
                pc_IF_ID    <= pc;
                instr_IF_ID <= word;
                valid_IF_ID <= 1'b1;
            end else begin
                instr_IF_ID <= NOP_INSTR;
                valid_IF_ID <= 1'b0;
            end
        end
    end
endmodule
